// File: rtl/bit_serial_add_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder sequencer.
// The master issues start/operands; the slave (the sequencer) returns
// busy/done and the held result.
interface bit_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell is time-shared to add
// two WIDTH-bit operands LSB first, one bit per clock. The result is
// published on sum/cout only when the final bit is computed and held
// until the next completion.
// Optional macro APPROX_LSB_EN: the low APPROX_BITS positions use a
// carry-free OR approximation and the carry chain restarts at zero
// above them.
module bit_serial_add_ctrl #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bit_serial_add_ctrl_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("WIDTH must be at least 2");
    end
    if (APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_approx
      $error("APPROX_BITS must lie in 0..WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   psum;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic               accept;
  logic               last_bit;
  logic               bit_s;
  logic               bit_c;
  logic [WIDTH-1:0]   psum_nxt;

  // Single full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

`ifdef APPROX_LSB_EN
  logic approx_pos;
  assign approx_pos = ({1'b0, cnt} < (CNT_W + 1)'(APPROX_BITS));

  // Low positions: OR approximation with the carry killed; others exact.
  always_comb begin
    bit_s = 1'b0;
    bit_c = 1'b0;
    if (approx_pos) begin
      bit_s = a_sh[0] | b_sh[0];
      bit_c = 1'b0;
    end else begin
      {bit_c, bit_s} = fa(a_sh[0], b_sh[0], carry);
    end
  end
`else
  // Every position uses the exact full adder.
  always_comb begin
    bit_s = 1'b0;
    bit_c = 1'b0;
    {bit_c, bit_s} = fa(a_sh[0], b_sh[0], carry);
  end
`endif

  assign psum_nxt = {bit_s, psum[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: RUN lasts until the last bit, DONE is one cycle
  // unless a new start is taken directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, carry flop, counter and partial sum; result is
  // latched only on the final bit so intermediate bits never show.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      psum   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      carry <= bus.cin;
      psum  <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= bit_c;
      psum  <= psum_nxt;
      cnt   <= cnt + 1'b1;
      if (last_bit) begin
        sum_q  <= psum_nxt;
        cout_q <= bit_c;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench for bit_serial_add_ctrl. Expected results come from
// a word-level arithmetic model of the add (and of the OR-approximated
// low bits when APPROX_LSB_EN is defined).
module tb_bit_serial_add_ctrl;
  localparam int W = 16;
  localparam int K = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bit_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  bit_serial_add_ctrl #(.WIDTH(W), .APPROX_BITS(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Word-level reference: {cout,sum}.
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic ci);
    logic [W:0] r;
`ifdef APPROX_LSB_EN
    logic [W:0] hi;
    logic [W:0] mask;
    if (K == 0) begin
      r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    end else begin
      mask = ((W + 1)'(1) << K) - 1'b1;
      hi   = ({1'b0, av} >> K) + ({1'b0, bv} >> K);
      r    = ((hi << K) & ~mask) | ({1'b0, av | bv} & mask);
    end
`else
    r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: latency, busy window, held result, done pulse width.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       input string nm);
    logic [W:0]   exp;
    logic [W-1:0] prev_sum;
    int           n;
    exp      = model(av, bv, ci);
    prev_sum = bus.sum;
    bus.a = av; bus.b = bv; bus.cin = ci; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.sum !== prev_sum) begin
        errors++;
        $display("FAIL %s_run: cyc=%0d busy=%b sum=%h required busy=1 sum=%h", nm, n, bus.busy,
                 bus.sum, prev_sum);
      end
      tick();
      n++;
    end
    checks++;
    if (n !== W) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles required %0d", nm, n, W);
    end
    checks++;
    if ({bus.cout, bus.sum} !== exp || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: got cout=%b sum=%h busy=%b required cout=%b sum=%h busy=0", nm,
               bus.cout, bus.sum, bus.busy, exp[W], exp[W-1:0]);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.cout, bus.sum} !== exp) begin
      errors++;
      $display("FAIL %s_after: done=%b busy=%b sum=%h required done=0 busy=0 sum=%h", nm,
               bus.done, bus.busy, bus.sum, exp[W-1:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.a = '1; bus.b = '1; bus.cin = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b required all 0", bus.busy, bus.done,
               bus.sum, bus.cout);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_exact();
    do_op(16'h1234, 16'h0FED, 1'b0, "exact");
`ifndef APPROX_LSB_EN
    checks++;
    if (bus.sum !== 16'h2221 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL exact_const: got %b/%h required 0/2221", bus.cout, bus.sum);
    end
`endif
  endtask

  task automatic test_wrap_cin();
    do_op(16'hFFFF, 16'h0001, 1'b0, "wrap");
`ifndef APPROX_LSB_EN
    checks++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin
      errors++;
      $display("FAIL wrap_const: got %b/%h required 1/0000", bus.cout, bus.sum);
    end
`endif
    do_op(16'h0000, 16'h0000, 1'b1, "cin");
`ifndef APPROX_LSB_EN
    checks++;
    if (bus.sum !== 16'h0001 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL cin_const: got %b/%h required 0/0001", bus.cout, bus.sum);
    end
`endif
    do_op(16'hFFFF, 16'hFFFF, 1'b1, "max");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_start_ignored();
    logic [W:0] exp;
    int         pulses;
    int         first;
    exp = model(16'h0001, 16'h0001, 1'b0);
    bus.a = 16'h0001; bus.b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    first  = -1;
    for (int n = 0; n < 45; n++) begin
      if (n == 5) begin
        bus.a = 16'h00FF; bus.b = 16'h00FF; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = n;
          checks++;
          if ({bus.cout, bus.sum} !== exp) begin
            errors++;
            $display("FAIL ignore_sum: got %b/%h required %b/%h", bus.cout, bus.sum, exp[W],
                     exp[W-1:0]);
          end
        end
      end
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (pulses !== 1 || first !== W) begin
      errors++;
      $display("FAIL ignore_pulses: got %0d pulses first at %0d required 1 at %0d", pulses,
               first, W);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp1;
    logic [W:0] exp2;
    int         n;
    exp1 = model(16'h0005, 16'h0009, 1'b0);
    exp2 = model(16'h0003, 16'h0004, 1'b0);
    bus.a = 16'h0005; bus.b = 16'h0009; bus.cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== W || {bus.cout, bus.sum} !== exp1) begin
      errors++;
      $display("FAIL b2b_first: latency %0d sum %h required %0d %h", n, bus.sum, W,
               exp1[W-1:0]);
    end
    bus.a = 16'h0003; bus.b = 16'h0004; bus.cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_nobubble: busy=%b done=%b required busy=1 done=0", bus.busy, bus.done);
    end
    n = 1;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== W + 1 || {bus.cout, bus.sum} !== exp2) begin
      errors++;
      $display("FAIL b2b_second: spacing %0d sum %h required %0d %h", n, bus.sum, W + 1,
               exp2[W-1:0]);
    end
`ifndef APPROX_LSB_EN
    checks++;
    if (bus.sum !== 16'h0007) begin
      errors++;
      $display("FAIL b2b_const: got %h required 0007", bus.sum);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    bus.a = 16'hA5A5; bus.b = 16'h5A5A; bus.cin = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b done=%b sum=%h cout=%b required all 0", bus.busy,
               bus.done, bus.sum, bus.cout);
    end
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midrst_quiet: got %0d active cycles required 0", pulses);
    end
    do_op(16'h1111, 16'h2222, 1'b1, "midrst_fresh");
  endtask

`ifdef APPROX_LSB_EN
  task automatic test_approx();
    do_op(16'h000F, 16'h0001, 1'b1, "approx_low");
    checks++;
    if (bus.sum !== 16'h000F || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL approx_low_const: got %b/%h required 0/000F", bus.cout, bus.sum);
    end
    do_op(16'h0010, 16'h0010, 1'b0, "approx_high");
    checks++;
    if (bus.sum !== 16'h0020 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL approx_high_const: got %b/%h required 0/0020", bus.cout, bus.sum);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    test_reset();
    test_exact();
    test_wrap_cin();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
`ifdef APPROX_LSB_EN
    test_approx();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_serial_add_ctrl.md
Name: bit_serial_add_ctrl

Overview:
- Sequencer that time-shares one FA cell to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.
- Owns operand shift registers, the carry flop, the bit counter and a start/busy/done handshake.
- Used as the low-area accumulation step for multiplier partial-product sums.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 2).
- APPROX_BITS, 4, number of low bit positions computed approximately when APPROX_LSB_EN is defined (0..WIDTH). Ignored otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high in RUN.
- done  output  1  single-cycle pulse, high in DONE.
- sum  output  WIDTH  last completed result; held until the next completion.
- cout  output  1  carry-out of the last completed result; held.

Behaviour:
- Reset, synchronous, rst=1 at a rising edge:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Bit counter, operand shift registers, carry flop and partial-sum register all 0.
  - rst overrides start.
- States IDLE, RUN, DONE.
- Start acceptance:
  - IDLE: start=1 at an edge captures a, b and cin (into the carry flop), clears the counter, and moves to RUN.
  - RUN: start is ignored. Operands and cin are not re-sampled.
  - DONE: start=1 is accepted as in IDLE, giving back-to-back operation with no IDLE bubble.
  - DONE with start=0: move to IDLE.
- RUN, each cycle:
  - The single FA computes from a_sh[0], b_sh[0] and carry.
  - At the edge, the FA sum bit shifts into the MSB of the partial-sum register (right shift), the carry flop takes the FA carry, a_sh and b_sh shift right, and cnt increments.
  - When cnt==WIDTH-1 at an edge:
    - sum <= final partial-sum value, including this bit.
    - cout <= FA carry.
    - state moves to DONE.
- Latency: start accepted at edge E0. RUN occupies exactly WIDTH cycles. done is high from E0+WIDTH to E0+WIDTH+1.
- busy=1 only in RUN. done=1 only in DONE, so done and busy are never both high.
- sum and cout change only at the RUN->DONE edge or at reset. Intermediate bits are never visible on sum.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Wrap-around is exact. Counter width is clog2(WIDTH).
- Reset asserted mid-RUN aborts the operation and returns to the reset state. No done pulse is produced.

Optional Feature:
- Macro: APPROX_LSB_EN.
- Defined:
  - For bit positions 0..APPROX_BITS-1, the result bit is a_bit OR b_bit and the carry flop is forced to 0.
  - cin is ignored when APPROX_BITS > 0.
  - Bits APPROX_BITS..WIDTH-1 use the exact FA, with carry-in 0 at bit APPROX_BITS.
  - Latency and handshake are unchanged.
  - APPROX_BITS=0 gives fully exact behaviour.
- Not defined: every bit uses the exact FA and APPROX_BITS has no effect.

Test Plan:
- Exact add: a=16'h1234, b=16'h0FED, cin=0, start for one cycle -> busy high for 16 cycles; done pulses 1 cycle at E0+16; sum=16'h2221, cout=0.
- Wrap and carry-in:
  - a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1.
  - a=0, b=0, cin=1 -> sum=16'h0001, cout=0.
- Start ignored while busy: start a=1, b=1; then pulse start with a=16'h00FF, b=16'h00FF at cycle 5 of RUN -> only one done pulse, at E0+16, with sum=16'h0002. Operands are unchanged.
- Back-to-back: hold start=1 with a new pair (16'h0003+16'h0004) during DONE -> next RUN begins with no IDLE cycle; second done at 17 cycles after the first, sum=16'h0007.
- Reset mid-run: rst=1 at RUN cycle 8 -> next cycle busy=0, done=0, sum=0, cout=0, state IDLE; no done pulse follows; a fresh start then completes correctly.
- Approximate, macro defined, APPROX_BITS=4:
  - a=16'h000F, b=16'h0001, cin=1 -> sum=16'h000F, cout=0 (exact result would be 16'h0011).
  - a=16'h0010, b=16'h0010 -> sum=16'h0020.
